// File: rtl/pcs_sync_fsm_param.sv
// 1000BASE-X receive code-group synchroniser with parametrised acquisition,
// degradation depth and recovery length, plus a saturating loss-of-sync counter.
module pcs_sync_fsm_param #(
  parameter int ACQ_COMMAS  = 3,
  parameter int GOOD_CGS    = 3,
  parameter int LOSS_LEVELS = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             signal_detect,
  input  logic [9:0]       rx_code_group,
  input  logic             cg_valid,
  input  logic             cg_is_data,
  input  logic             cnt_clr,
  output logic [9:0]       rx_code_group_out,
  output logic             sync_status,
  output logic             rx_even,
  output logic [2:0]       sync_level,
  output logic [CNT_W-1:0] loss_count
);

  localparam logic [3:0] ACQ_N   = 4'(ACQ_COMMAS);
  localparam logic [3:0] GOOD_N  = 4'(GOOD_CGS);
  localparam logic [2:0] LVL_MAX = 3'(LOSS_LEVELS);

  typedef enum logic [1:0] {
    ST_LOSS = 2'd0,
    ST_CDET = 2'd1,
    ST_ACQ  = 2'd2,
    ST_SYNC = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [3:0]       r_acq_cnt;
  logic [3:0]       w_acq_nx;
  logic [3:0]       r_good_cnt;
  logic [3:0]       w_good_nx;
  logic [2:0]       r_level;
  logic [2:0]       w_level_nx;
  logic             r_even;
  logic             w_even_nx;
  logic             w_even_set;
  logic             w_loss_evt;
  logic [CNT_W-1:0] r_loss_cnt;
  logic [9:0]       r_cg_dly;
  logic             w_comma;
  logic             w_cgbad;
  logic             w_synced;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Both comma polarities are accepted so detection is independent of disparity.
  assign w_comma   = (rx_code_group[9:3] == 7'b0011111) ||
                     (rx_code_group[9:3] == 7'b1100000);
  assign w_cgbad   = !cg_valid || (w_comma && r_even);
  assign w_even_nx = w_even_set ? 1'b1 : ~r_even;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state    <= ST_LOSS;
      r_acq_cnt  <= 4'd0;
      r_good_cnt <= 4'd0;
      r_level    <= 3'd0;
      r_even     <= 1'b0;
      r_cg_dly   <= 10'd0;
    end else begin
      r_state    <= w_state_nx;
      r_acq_cnt  <= w_acq_nx;
      r_good_cnt <= w_good_nx;
      r_level    <= w_level_nx;
      r_even     <= w_even_nx;
      r_cg_dly   <= rx_code_group;
    end
  end

  // cnt_clr wins over a coincident loss event.
  always_ff @(posedge clk) begin
    if (RESET || cnt_clr) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt) begin
      r_loss_cnt <= sat_inc(r_loss_cnt);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_acq_nx   = r_acq_cnt;
    w_good_nx  = r_good_cnt;
    w_level_nx = r_level;
    w_even_set = 1'b0;
    w_loss_evt = 1'b0;
    if (!signal_detect) begin
      w_state_nx = ST_LOSS;
      w_acq_nx   = 4'd0;
      w_good_nx  = 4'd0;
      w_level_nx = 3'd0;
      w_loss_evt = (r_state == ST_SYNC);
    end else begin
      case (r_state)
        ST_LOSS: begin
          if (w_comma) begin
            w_state_nx = ST_CDET;
            w_acq_nx   = 4'd1;
            w_even_set = 1'b1;
          end
        end
        ST_CDET: begin
          if (cg_valid && cg_is_data) begin
            if (r_acq_cnt == ACQ_N) begin
              w_state_nx = ST_SYNC;
              w_level_nx = 3'd0;
              w_good_nx  = 4'd0;
            end else begin
              w_state_nx = ST_ACQ;
            end
          end else begin
            w_state_nx = ST_LOSS;
            w_acq_nx   = 4'd0;
          end
        end
        ST_ACQ: begin
          if (w_cgbad) begin
            w_state_nx = ST_LOSS;
            w_acq_nx   = 4'd0;
          end else if (w_comma) begin
            w_state_nx = ST_CDET;
            w_acq_nx   = r_acq_cnt + 4'd1;
            w_even_set = 1'b1;
          end
        end
        ST_SYNC: begin
          if (w_cgbad) begin
            w_good_nx = 4'd0;
            if (r_level == LVL_MAX) begin
              w_state_nx = ST_LOSS;
              w_level_nx = 3'd0;
              w_acq_nx   = 4'd0;
              w_loss_evt = 1'b1;
            end else begin
              w_level_nx = r_level + 3'd1;
            end
          end else if (r_level != 3'd0) begin
            if (r_good_cnt + 4'd1 == GOOD_N) begin
              w_level_nx = r_level - 3'd1;
              w_good_nx  = 4'd0;
            end else begin
              w_good_nx = r_good_cnt + 4'd1;
            end
          end else begin
            w_good_nx = 4'd0;
          end
        end
        default: w_state_nx = ST_LOSS;
      endcase
    end
  end

  always_comb begin
    w_synced          = (r_state == ST_SYNC);
    sync_status       = w_synced;
    sync_level        = w_synced ? r_level : 3'd0;
    rx_even           = r_even;
    rx_code_group_out = r_cg_dly;
    loss_count        = r_loss_cnt;
  end

endmodule

// File: tb/tb_pcs_sync_fsm_param.sv
// Bench for pcs_sync_fsm_param: directed scenarios with literal expectations,
// then randomised traffic compared every cycle against a behavioural model.
module tb_pcs_sync_fsm_param;
  localparam int AC = 3;
  localparam int GC = 3;
  localparam int LL = 3;
  localparam int CW = 2;
  localparam logic [9:0] K28N = 10'b0011111010;
  localparam logic [9:0] K28P = 10'b1100000101;
  localparam logic [9:0] D56  = 10'b1010010110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RESET, signal_detect, cg_valid, cg_is_data, cnt_clr;
  logic [9:0]    rx_code_group;
  logic [9:0]    rx_code_group_out;
  logic          sync_status, rx_even;
  logic [2:0]    sync_level;
  logic [CW-1:0] loss_count;

  pcs_sync_fsm_param #(.ACQ_COMMAS(AC), .GOOD_CGS(GC), .LOSS_LEVELS(LL), .CNT_W(CW)) dut (
    .clk(clk), .RESET(RESET), .signal_detect(signal_detect),
    .rx_code_group(rx_code_group), .cg_valid(cg_valid), .cg_is_data(cg_is_data),
    .cnt_clr(cnt_clr), .rx_code_group_out(rx_code_group_out),
    .sync_status(sync_status), .rx_even(rx_even), .sync_level(sync_level),
    .loss_count(loss_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: synced flag, commas collected so far, and whether a data word is awaited.
  bit       m_synced, m_wait, m_even, m_en;
  int       m_acq, m_good, m_level, m_loss;
  logic [9:0] m_cg;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    bit comma, bad, eset, inc;
    if (RESET) begin
      m_synced = 0; m_wait = 0; m_acq = 0; m_good = 0; m_level = 0;
      m_even = 0; m_loss = 0; m_cg = '0;
      return;
    end
    comma = (rx_code_group[9:3] == 7'b0011111) || (rx_code_group[9:3] == 7'b1100000);
    bad   = !cg_valid || (comma && m_even);
    eset  = 0;
    inc   = 0;
    m_cg  = rx_code_group;
    if (!signal_detect) begin
      inc = m_synced;
      m_synced = 0; m_wait = 0; m_acq = 0; m_good = 0; m_level = 0;
    end else if (m_synced) begin
      if (bad) begin
        m_good = 0;
        if (m_level == LL) begin m_synced = 0; m_level = 0; m_acq = 0; inc = 1; end
        else m_level++;
      end else if (m_level > 0) begin
        m_good++;
        if (m_good == GC) begin m_level--; m_good = 0; end
      end else m_good = 0;
    end else if (m_wait) begin
      m_wait = 0;
      if (cg_valid && cg_is_data) begin
        if (m_acq == AC) begin m_synced = 1; m_level = 0; m_good = 0; m_acq = 0; end
      end else m_acq = 0;
    end else if (m_acq > 0) begin
      if (bad) m_acq = 0;
      else if (comma) begin m_acq++; m_wait = 1; eset = 1; end
    end else if (comma) begin
      m_acq = 1; m_wait = 1; eset = 1;
    end
    m_even = eset ? 1'b1 : !m_even;
    if (cnt_clr) m_loss = 0;
    else if (inc && m_loss < (1 << CW) - 1) m_loss++;
  endtask

  task automatic drive(input logic sd, input logic [9:0] cg, input logic v,
                       input logic d, input logic clr, input logic rst);
    signal_detect = sd; rx_code_group = cg; cg_valid = v; cg_is_data = d;
    cnt_clr = clr; RESET = rst;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic send_k();   drive(1'b1, K28N, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic send_d();   drive(1'b1, D56,  1'b1, 1'b1, 1'b0, 1'b0); endtask
  task automatic send_bad(); drive(1'b1, D56,  1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic acquire();
    for (int i = 0; i < AC; i++) begin send_k(); send_d(); end
  endtask

  always @(negedge clk) begin
    if (m_en) begin
      check("sync_status", sync_status, m_synced);
      check("rx_even", rx_even, m_even);
      check("sync_level", sync_level, m_level);
      check("loss_count", loss_count, m_loss);
      check("cg_out", rx_code_group_out, m_cg);
    end
  end

  initial begin
    logic [9:0] cg;
    logic v, d, sd, clr, rst;
    bit want_k;
    m_en = 0;
    drive(1'b1, D56, 1'b1, 1'b1, 1'b0, 1'b1);
    m_en = 1;
    drive(1'b1, D56, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_sync", sync_status, 0);
    check("rst_even", rx_even, 0);
    check("rst_level", sync_level, 0);
    check("rst_loss", loss_count, 0);
    check("rst_cgout", rx_code_group_out, 0);

    // Aborted acquisition: second comma arrives where data is expected.
    send_k(); send_k();
    check("abort_sync", sync_status, 0);

    for (int i = 0; i < AC; i++) begin
      send_k();
      check("acq_even_k", rx_even, 1);
      check("acq_sync_k", sync_status, 0);
      send_d();
      check("acq_even_d", rx_even, 0);
    end
    check("acq_sync", sync_status, 1);
    check("acq_level", sync_level, 0);
    check("acq_cgout", rx_code_group_out, D56);

    for (int i = 1; i <= LL; i++) begin
      send_bad();
      check("degr_level", sync_level, i);
      check("degr_sync", sync_status, 1);
    end
    send_bad();
    check("loss_sync", sync_status, 0);
    check("loss_cnt1", loss_count, 1);

    acquire();
    send_bad(); send_bad();
    check("rec_lvl2", sync_level, 2);
    send_d(); send_d();
    check("rec_hold", sync_level, 2);
    send_d();
    check("rec_lvl1", sync_level, 1);
    send_bad();
    check("rec_bad", sync_level, 2);
    send_d(); send_d();
    check("rec_goodrst", sync_level, 2);
    send_d();
    check("rec_lvl1b", sync_level, 1);
    send_d(); send_d(); send_d();
    check("rec_lvl0", sync_level, 0);

    if (!m_even) send_d();
    send_k();
    check("misalign_lvl", sync_level, 1);
    check("misalign_sync", sync_status, 1);

    drive(1'b0, D56, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sd_sync", sync_status, 0);
    check("sd_loss", loss_count, 2);
    acquire(); drive(1'b0, D56, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sd_loss3", loss_count, 3);
    acquire(); drive(1'b0, D56, 1'b1, 1'b1, 1'b0, 1'b0);
    acquire(); drive(1'b0, D56, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sat_loss", loss_count, 3);

    acquire();
    drive(1'b0, D56, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_loss", loss_count, 0);
    check("clr_sync", sync_status, 0);

    acquire();
    send_bad();
    check("pre_rst_lvl", sync_level, 1);
    drive(1'b1, D56, 1'b1, 1'b1, 1'b0, 1'b1);
    check("mid_rst_sync", sync_status, 0);
    check("mid_rst_even", rx_even, 0);
    check("mid_rst_lvl", sync_level, 0);
    check("mid_rst_cg", rx_code_group_out, 0);

    for (int i = 0; i < 3000; i++) begin
      want_k = !m_even ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      if (want_k) begin
        cg = ($urandom_range(0, 1) != 0) ? K28N : K28P;
        d  = 1'b0;
      end else begin
        cg = 10'($urandom_range(0, 1023));
        if (cg[9:3] == 7'b0011111 || cg[9:3] == 7'b1100000) cg = D56;
        d = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) d = ~d;
      v   = ($urandom_range(0, 24) != 0);
      sd  = ($urandom_range(0, 99) != 0);
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 299) == 0);
      drive(sd, cg, v, d, clr, rst);
    end

    @(negedge clk);
    m_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
